return_addr_stack: RTL and testbench

//  Hardware return-address stack serving the program counter's subroutine path.
//  On a jump-to-subroutine it pushes the return address (current rp + 1).
//  On a return-from-subroutine the PC loads rl, the registered top entry, and the entry is popped.

---
 rtl/return_addr_stack.sv | 159 +++++++++++++++
 tb/tb_return_addr_stack.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/return_addr_stack.sv
// -----------------------------------------------------------------------------
// return_addr_stack
//
// Hardware return-address stack for the program counter's subroutine path.
// A jump-to-subroutine pushes the return address (rp + 1). A return pops the
// stack, and the PC loads rl, which is the registered top-of-stack entry.
// A push and a pop in the same cycle (tail call) replace the top entry.
//
// Ports
//   clk        in   1        clock, all state updates on the rising edge
//   rst_n      in   1        synchronous active-low reset
//   jump2sub   in   1        push request (the PC jump strobe)
//   retFsub    in   1        pop request (the PC load-from-rl strobe)
//   rp         in   ADDR_W   current program address
//   clr_err    in   1        clears the sticky overflow/underflow flags
//   rl         out  ADDR_W   registered top-of-stack return address
//   count      out  CNT_W    number of valid entries
//   empty      out  1        count == 0
//   full       out  1        count == DEPTH
//   overflow   out  1        sticky: push attempted while full
//   underflow  out  1        sticky: pop attempted while empty
// -----------------------------------------------------------------------------
module return_addr_stack #(
  parameter  int ADDR_W = 10,
  parameter  int DEPTH  = 8,
  localparam int CNT_W  = $clog2(DEPTH + 1),
  localparam int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              jump2sub,
  input  logic              retFsub,
  input  logic [ADDR_W-1:0] rp,
  input  logic              clr_err,
  output logic [ADDR_W-1:0] rl,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow
);

  // Resolved operation for this cycle.
  typedef enum logic [2:0] {
    OP_IDLE,       // neither strobe
    OP_PUSH,       // push with room (also push+pop on an empty stack)
    OP_OVERFLOW,   // push while full: dropped
    OP_POP,        // pop with at least one entry
    OP_UNDERFLOW,  // pop while empty: dropped
    OP_REPLACE     // push+pop with at least one entry: tail call
  } op_e;

  // State
  logic [ADDR_W-1:0] entries_q [DEPTH];
  logic [ADDR_W-1:0] entries_d [DEPTH];
  logic [CNT_W-1:0]  count_q,     count_d;
  logic [ADDR_W-1:0] rl_q,        rl_d;
  logic              overflow_q,  overflow_d;
  logic              underflow_q, underflow_d;

  // Decode
  op_e               op;
  logic [ADDR_W-1:0] ret_addr;
  logic              is_empty;
  logic              is_full;
  logic [IDX_W-1:0]  wr_idx;     // first free slot (valid when not full)
  logic [IDX_W-1:0]  top_idx;    // current top (valid when not empty)
  logic [IDX_W-1:0]  below_idx;  // entry under the top (valid when count >= 2)

  // Return address wraps naturally at the top of the address space.
  assign ret_addr  = rp + ADDR_W'(1);

  assign is_empty  = (count_q == '0);
  assign is_full   = (count_q == CNT_W'(DEPTH));

  // Truncation to IDX_W is safe: each index is used only in the states where
  // the untruncated value lies in 0..DEPTH-1.
  assign wr_idx    = IDX_W'(count_q);
  assign top_idx   = IDX_W'(count_q - CNT_W'(1));
  assign below_idx = IDX_W'(count_q - CNT_W'(2));

  always_comb begin
    // NOTE: every signal written in a combinational block gets a default first,
    // so no path leaves it unassigned and no latch is inferred.
    op = OP_IDLE;
    unique case ({jump2sub, retFsub})
      2'b10:   op = is_full  ? OP_OVERFLOW  : OP_PUSH;
      2'b01:   op = is_empty ? OP_UNDERFLOW : OP_POP;
      2'b11:   op = is_empty ? OP_PUSH      : OP_REPLACE;
      default: op = OP_IDLE;
    endcase
  end

  // Next-state logic
  always_comb begin
    entries_d   = entries_q;
    count_d     = count_q;
    rl_d        = rl_q;
    // Clear first so that an error event later in this block wins over clr_err.
    overflow_d  = clr_err ? 1'b0 : overflow_q;
    underflow_d = clr_err ? 1'b0 : underflow_q;

    unique case (op)
      OP_PUSH: begin
        entries_d[wr_idx] = ret_addr;
        count_d           = count_q + CNT_W'(1);
        rl_d              = ret_addr;
      end
      OP_OVERFLOW: begin
        overflow_d = 1'b1;
      end
      OP_POP: begin
        count_d = count_q - CNT_W'(1);
        // Popping the last entry exposes nothing: rl reads as zero.
        rl_d    = (count_q == CNT_W'(1)) ? '0 : entries_q[below_idx];
      end
      OP_UNDERFLOW: begin
        underflow_d = 1'b1;
      end
      OP_REPLACE: begin
        entries_d[top_idx] = ret_addr;
        rl_d               = ret_addr;
      end
      default: ;  // OP_IDLE: hold
    endcase
  end

  // State registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the entry array is reset as well, so a stale address can never
      // reappear on rl; it is small enough that this costs little.
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
      count_q     <= '0;
      rl_q        <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values, independent of statement order.
      entries_q   <= entries_d;
      count_q     <= count_d;
      rl_q        <= rl_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Outputs
  assign rl        = rl_q;
  assign count     = count_q;
  assign empty     = is_empty;
  assign full      = is_full;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_return_addr_stack.sv
// -----------------------------------------------------------------------------
// tb_return_addr_stack
//
// Self-checking bench for return_addr_stack (ADDR_W=10, DEPTH=8).
// A directed vector table covers reset, push/pop sequences, address wrap,
// fill/overflow, underflow, tail calls, flag clearing and reset mid-sequence.
// It is followed by a randomized run checked against a queue-based model.
// Each applied vector puts its expected outputs on a scoreboard queue; after
// the clock edge the entry is popped and compared against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_return_addr_stack;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              jump2sub;
  logic              retFsub;
  logic [ADDR_W-1:0] rp;
  logic              clr_err;
  logic [ADDR_W-1:0] rl;
  logic [CNT_W-1:0]  count;
  logic              empty;
  logic              full;
  logic              overflow;
  logic              underflow;

  return_addr_stack #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .jump2sub  (jump2sub),
    .retFsub   (retFsub),
    .rp        (rp),
    .clr_err   (clr_err),
    .rl        (rl),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              rst_n;
    logic              push;
    logic              pop;
    logic              clr;
    logic [ADDR_W-1:0] rp;
    logic [CNT_W-1:0]  exp_cnt;
    logic [ADDR_W-1:0] exp_rl;
    logic              exp_ov;
    logic              exp_un;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  int n_vec = 0;
  int n_err = 0;
  int step_no = 0;

  // Reference model for the random phase: a plain queue used as a stack.
  logic [ADDR_W-1:0] mdl[$];
  logic              mdl_ov;
  logic              mdl_un;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL step %0d %s: got 0x%0h, expected 0x%0h", step_no, name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic push, input logic pop, input logic clr,
                     input logic [ADDR_W-1:0] a, input logic [CNT_W-1:0] cnt,
                     input logic [ADDR_W-1:0] exp_rl, input logic ov, input logic un);
    vec_t v;
    v.rst_n = r;  v.push = push; v.pop = pop; v.clr = clr; v.rp = a;
    v.exp_cnt = cnt; v.exp_rl = exp_rl; v.exp_ov = ov; v.exp_un = un;
    vecs.push_back(v);
  endtask

  // Drive one vector, record its expectation, clock once, compare #1 later.
  task automatic step(input vec_t v);
    vec_t e;
    rst_n    = v.rst_n;
    jump2sub = v.push;
    retFsub  = v.pop;
    clr_err  = v.clr;
    rp       = v.rp;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    step_no++;
    e = exp_q.pop_front();
    check("rl",        32'(rl),        32'(e.exp_rl));
    check("count",     32'(count),     32'(e.exp_cnt));
    check("empty",     32'(empty),     32'(e.exp_cnt == '0));
    check("full",      32'(full),      32'(e.exp_cnt == CNT_W'(DEPTH)));
    check("overflow",  32'(overflow),  32'(e.exp_ov));
    check("underflow", 32'(underflow), 32'(e.exp_un));
  endtask

  // Advance the model by one cycle and return the resulting expectation.
  task automatic model_step(input logic r, input logic push, input logic pop,
                            input logic clr, input logic [ADDR_W-1:0] a, output vec_t v);
    logic [ADDR_W-1:0] ret;
    ret = a + ADDR_W'(1);
    if (!r) begin
      mdl.delete();
      mdl_ov = 1'b0;
      mdl_un = 1'b0;
    end else begin
      if (clr) begin
        mdl_ov = 1'b0;
        mdl_un = 1'b0;
      end
      if (push && pop) begin
        if (mdl.size() == 0) mdl.push_back(ret);
        else                 mdl[mdl.size()-1] = ret;
      end else if (push) begin
        if (mdl.size() == DEPTH) mdl_ov = 1'b1;
        else                     mdl.push_back(ret);
      end else if (pop) begin
        if (mdl.size() == 0) mdl_un = 1'b1;
        else                 void'(mdl.pop_back());
      end
    end
    v.rst_n = r; v.push = push; v.pop = pop; v.clr = clr; v.rp = a;
    v.exp_cnt = CNT_W'(mdl.size());
    v.exp_rl  = (mdl.size() == 0) ? '0 : mdl[mdl.size()-1];
    v.exp_ov  = mdl_ov;
    v.exp_un  = mdl_un;
  endtask

  initial begin
    vec_t v;

    rst_n = 1'b0; jump2sub = 1'b0; retFsub = 1'b0; clr_err = 1'b0; rp = '0;

    //  rst push pop clr rp       cnt rl      ov un
    // Reset, and reset overriding every other input
    add(0, 0, 0, 0, 10'h000,  0, 10'h000, 0, 0);
    add(0, 1, 1, 1, 10'h155,  0, 10'h000, 0, 0);
    // Single push, hold, pop
    add(1, 1, 0, 0, 10'h0FF,  1, 10'h100, 0, 0);
    add(1, 0, 0, 0, 10'h000,  1, 10'h100, 0, 0);
    add(1, 0, 1, 0, 10'h000,  0, 10'h000, 0, 0);
    // Three nested calls then three returns
    add(1, 1, 0, 0, 10'h010,  1, 10'h011, 0, 0);
    add(1, 1, 0, 0, 10'h020,  2, 10'h021, 0, 0);
    add(1, 1, 0, 0, 10'h030,  3, 10'h031, 0, 0);
    add(1, 0, 1, 0, 10'h000,  2, 10'h021, 0, 0);
    add(1, 0, 1, 0, 10'h000,  1, 10'h011, 0, 0);
    add(1, 0, 1, 0, 10'h000,  0, 10'h000, 0, 0);
    // Return address wraps at the top of the address space
    add(1, 1, 0, 0, 10'h3FF,  1, 10'h000, 0, 0);
    add(1, 0, 1, 0, 10'h000,  0, 10'h000, 0, 0);
    // Fill to DEPTH
    for (int i = 0; i < DEPTH; i++)
      add(1, 1, 0, 0, ADDR_W'(10'h100 + i), CNT_W'(i + 1), ADDR_W'(10'h101 + i), 0, 0);
    // Push while full, clear, clear colliding with a new overflow, clear again
    add(1, 1, 0, 0, 10'h200,  8, 10'h108, 1, 0);
    add(1, 0, 0, 1, 10'h000,  8, 10'h108, 0, 0);
    add(1, 1, 0, 1, 10'h201,  8, 10'h108, 1, 0);
    add(1, 0, 0, 1, 10'h000,  8, 10'h108, 0, 0);
    // Tail call while full replaces the top entry only
    add(1, 1, 1, 0, 10'h2AF,  8, 10'h2B0, 0, 0);
    // Drain: the entries beneath the replaced top are intact
    for (int i = DEPTH - 1; i >= 1; i--)
      add(1, 0, 1, 0, 10'h000, CNT_W'(i), ADDR_W'(10'h100 + i), 0, 0);
    add(1, 0, 1, 0, 10'h000,  0, 10'h000, 0, 0);
    // Pop on empty, then underflow stays sticky through legal operations
    add(1, 0, 1, 0, 10'h000,  0, 10'h000, 0, 1);
    add(1, 1, 0, 0, 10'h040,  1, 10'h041, 0, 1);
    add(1, 1, 0, 0, 10'h04F,  2, 10'h050, 0, 1);
    add(1, 1, 1, 0, 10'h050,  2, 10'h051, 0, 1);
    add(1, 0, 1, 0, 10'h000,  1, 10'h041, 0, 1);
    add(1, 0, 1, 0, 10'h000,  0, 10'h000, 0, 1);
    // Push+pop on empty acts as a push and raises no underflow
    add(1, 1, 1, 0, 10'h060,  1, 10'h061, 0, 1);
    add(1, 0, 1, 1, 10'h000,  0, 10'h000, 0, 0);
    add(1, 0, 1, 1, 10'h000,  0, 10'h000, 0, 1);
    add(1, 0, 0, 1, 10'h000,  0, 10'h000, 0, 0);

    foreach (vecs[i]) step(vecs[i]);

    // Reset mid-sequence at count=5 with a push pending, flags set beforehand
    step('{1, 0, 1, 0, 10'h000, 0, 10'h000, 0, 1});
    for (int i = 0; i < 5; i++) begin
      v = '{1, 1, 0, 0, ADDR_W'(10'h300 + i), CNT_W'(i + 1), ADDR_W'(10'h301 + i), 0, 1};
      step(v);
    end
    step('{0, 1, 0, 0, 10'h123, 0, 10'h000, 0, 0});
    step('{1, 1, 0, 0, 10'h001, 1, 10'h002, 0, 0});
    step('{1, 0, 1, 0, 10'h000, 0, 10'h000, 0, 0});

    // Randomized traffic against the queue model, starting from reset
    mdl.delete();
    mdl_ov = 1'b0;
    mdl_un = 1'b0;
    for (int n = 0; n < 400; n++) begin
      logic r, pu, po, cl;
      logic [ADDR_W-1:0] a;
      r  = (n == 0) ? 1'b0 : ($urandom_range(0, 59) != 0);
      pu = ($urandom_range(0, 99) < 55);
      po = ($urandom_range(0, 99) < 45);
      cl = ($urandom_range(0, 9) == 0);
      a  = ADDR_W'($urandom);
      model_step(r, pu, po, cl, a, v);
      step(v);
    end

    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard: %0d entries left, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
